// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the ID-stage hazard/stall logic.
// Register index is {is_fp, reg[4:0]}; only integer x0 is hardwired zero, f0 is a normal register.
package hazard_pkg;
  localparam int REG_IDX_W   = 6;
  localparam int FP_BIT      = 5;
  localparam int DIV_LAT_DEF = 16;
  localparam logic [REG_IDX_W-1:0] X0_IDX = 6'b0_00000;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  function automatic logic is_x0(input reg_idx_t idx);
    return (idx[FP_BIT] == X0_IDX[FP_BIT]) && (idx[FP_BIT-1:0] == X0_IDX[FP_BIT-1:0]);
  endfunction
endpackage

// File: rtl/hazard_scoreboard.sv
// Pending long-latency writer scoreboard: busy bit per register, set-over-clear priority.
// Lookups are combinational from registered busy bits; no clear-to-lookup bypass.
// No backpressure: set/clear are accepted every cycle.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG = 64
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     set_vld,
  input  reg_idx_t set_idx,
  input  logic     clr_vld,
  input  reg_idx_t clr_idx,
  input  reg_idx_t rs1,
  input  reg_idx_t rs2,
  input  reg_idx_t rs3,
  input  reg_idx_t rd,
  output logic     rs1_busy,
  output logic     rs2_busy,
  output logic     rs3_busy,
  output logic     rd_busy
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  // Clear first so a same-index set in the same cycle overrides it.
  always_comb begin
    busy_nxt = busy;
    if (clr_vld)
      busy_nxt[clr_idx] = 1'b0;
    if (set_vld && !is_x0(set_idx))
      busy_nxt[set_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  assign rs1_busy = busy[rs1] & ~is_x0(rs1);
  assign rs2_busy = busy[rs2] & ~is_x0(rs2);
  assign rs3_busy = busy[rs3] & ~is_x0(rs3);
  assign rd_busy  = busy[rd]  & ~is_x0(rd);

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage stall/bubble generation for load-use, long-op RAW/WAW and divider structural hazards.
// Latency: stall is combinational from registered state + current ID/EX/WB inputs; state updates next edge.
// Backpressure: stall holds PC and IF/ID and bubbles ID/EX. HAZARD_PERF_CNT_EN adds stall_cycles.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int NREG    = 64,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] id_rs3,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic                 id_use_rs3,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 id_reg_write,
  input  logic                 id_long_op,
  input  logic                 id_valid,
  input  logic                 id_flush,
  input  logic                 id_ex_mem_read,
  input  logic [REG_IDX_W-1:0] id_ex_rd,
  input  logic                 wb_long_valid,
  input  logic [REG_IDX_W-1:0] wb_long_rd,
  output logic                 stall,
  output logic                 id_ex_bubble,
  output logic                 div_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]          stall_cycles
`endif
);

  logic             rs1_busy, rs2_busy, rs3_busy, rd_busy;
  logic             load_use, raw_hit, waw_hit, struct_hit;
  logic             issue;
  logic             rst_q;
  logic [CNT_W-1:0] div_cnt;

  hazard_scoreboard #(.NREG(NREG)) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_vld  (issue),
    .set_idx  (id_rd),
    .clr_vld  (wb_long_valid),
    .clr_idx  (wb_long_rd),
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .rs3      (id_rs3),
    .rd       (id_rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rs3_busy (rs3_busy),
    .rd_busy  (rd_busy)
  );

  assign raw_hit    = (id_use_rs1 & rs1_busy) | (id_use_rs2 & rs2_busy) | (id_use_rs3 & rs3_busy);
  assign waw_hit    = id_reg_write & rd_busy;
  assign struct_hit = id_long_op & div_busy;
  assign load_use   = id_ex_mem_read & ~is_x0(id_ex_rd) &
                      ((id_use_rs1 & (id_rs1 == id_ex_rd)) |
                       (id_use_rs2 & (id_rs2 == id_ex_rd)) |
                       (id_use_rs3 & (id_rs3 == id_ex_rd)));

  // Stall is masked during reset and the first cycle out of it, while the pipe refills.
  assign stall        = id_valid & ~id_flush & ~rst & ~rst_q &
                        (load_use | raw_hit | waw_hit | struct_hit);
  assign id_ex_bubble = stall;
  assign issue        = id_valid & ~id_flush & ~stall & id_long_op;
  assign div_busy     = (div_cnt != '0);

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst)
      div_cnt <= '0;
    else if (issue)
      div_cnt <= CNT_W'(DIV_LAT);
    else if (div_busy)
      div_cnt <= div_cnt - CNT_W'(1);
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      stall_cycles <= '0;
    else if (stall)
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: driver queues expected outputs, negedge monitor checks them.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] id_rs1, id_rs2, id_rs3, id_rd, id_ex_rd, wb_long_rd;
  logic       id_use_rs1, id_use_rs2, id_use_rs3;
  logic       id_reg_write, id_long_op, id_valid, id_flush;
  logic       id_ex_mem_read, wb_long_valid;
  logic       stall, id_ex_bubble, div_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
  int unsigned sc_exp   = 0;
  bit          sc_known = 1'b0;
`endif

  always #5 clk = ~clk;

  hazard_stall_unit dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rs3         (id_rs3),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .id_use_rs3     (id_use_rs3),
    .id_rd          (id_rd),
    .id_reg_write   (id_reg_write),
    .id_long_op     (id_long_op),
    .id_valid       (id_valid),
    .id_flush       (id_flush),
    .id_ex_mem_read (id_ex_mem_read),
    .id_ex_rd       (id_ex_rd),
    .wb_long_valid  (wb_long_valid),
    .wb_long_rd     (wb_long_rd),
    .stall          (stall),
    .id_ex_bubble   (id_ex_bubble),
    .div_busy       (div_busy)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  typedef struct {
    logic  stall;
    logic  dbusy;
    logic  rst;
    string nm;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;

  localparam logic [5:0] F3  = 6'h23;
  localparam logic [5:0] F2  = 6'h22;
  localparam logic [5:0] F4  = 6'h24;
  localparam logic [5:0] F7  = 6'h27;
  localparam logic [5:0] F9  = 6'h29;
  localparam logic [5:0] F10 = 6'h2a;
  localparam logic [5:0] F0  = 6'h20;

  // Monitor: outputs are valid every cycle, compared mid-cycle against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (stall !== e.stall) begin
        failures++;
        $display("FAIL %s stall: got %b expected %b at %0t", e.nm, stall, e.stall, $time);
      end
      checks++;
      if (id_ex_bubble !== e.stall) begin
        failures++;
        $display("FAIL %s bubble: got %b expected %b at %0t", e.nm, id_ex_bubble, e.stall, $time);
      end
      checks++;
      if (div_busy !== e.dbusy) begin
        failures++;
        $display("FAIL %s div_busy: got %b expected %b at %0t", e.nm, div_busy, e.dbusy, $time);
      end
`ifdef HAZARD_PERF_CNT_EN
      if (sc_known) begin
        checks++;
        if (stall_cycles !== sc_exp) begin
          failures++;
          $display("FAIL %s stall_cycles: got %0d expected %0d", e.nm, stall_cycles, sc_exp);
        end
      end
      if (e.rst) begin
        sc_exp   = 0;
        sc_known = 1'b1;
      end else if (e.stall) begin
        sc_exp++;
      end
`endif
    end
  end

  task automatic clr_in();
    id_rs1 = '0; id_rs2 = '0; id_rs3 = '0; id_rd = '0; id_ex_rd = '0; wb_long_rd = '0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_use_rs3 = 0;
    id_reg_write = 0; id_long_op = 0; id_valid = 0; id_flush = 0;
    id_ex_mem_read = 0; wb_long_valid = 0;
  endtask

  task automatic issue_long(input logic [5:0] rd);
    id_valid = 1; id_long_op = 1; id_reg_write = 1; id_rd = rd;
  endtask

  // Queue the expectation for the inputs currently applied, then advance one cycle.
  task automatic cyc(input logic s, input logic db, input string nm);
    exp_t x;
    x.stall = s; x.dbusy = db; x.rst = rst; x.nm = nm;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_in();
    rst = 1;
    @(posedge clk);
    #1;
    // Load-use hazard present while in reset and the cycle after it
    id_valid = 1; id_rs1 = 6'd5; id_use_rs1 = 1; id_ex_mem_read = 1; id_ex_rd = 6'd5;
    cyc(0, 0, "rst_hold");
    cyc(0, 0, "rst_hold2");
    rst = 0;
    cyc(0, 0, "post_rst");

    // Load-use
    cyc(1, 0, "ld_use");
    id_ex_mem_read = 0;
    cyc(0, 0, "ld_use_done");
    id_ex_mem_read = 1; id_ex_rd = 6'd0; id_rs1 = 6'd0;
    cyc(0, 0, "ld_x0");
    id_ex_rd = 6'd5; id_rs1 = 6'd5; id_use_rs1 = 0;
    cyc(0, 0, "ld_unused");
    id_rs2 = 6'd5; id_use_rs2 = 1;
    cyc(1, 0, "ld_rs2");
    clr_in();
    id_valid = 1; id_ex_mem_read = 1; id_ex_rd = F0; id_rs3 = F0; id_use_rs3 = 1;
    cyc(1, 0, "ld_f0");
    id_valid = 0;
    cyc(0, 0, "ld_novalid");
    id_valid = 1; id_flush = 1;
    cyc(0, 0, "ld_flush");

    // RAW on fdiv f3: issue at t, dependent stalls through writeback at t+16
    clr_in(); issue_long(F3);
    cyc(0, 0, "raw_issue");
    clr_in();
    id_valid = 1; id_rs1 = F3; id_use_rs1 = 1; id_rs2 = F2; id_use_rs2 = 1;
    id_rd = F4; id_reg_write = 1;
    for (int k = 1; k <= 15; k++) cyc(1, 1, "raw_wait");
    wb_long_valid = 1; wb_long_rd = F3;
    cyc(1, 1, "raw_wb");
    wb_long_valid = 0;
    cyc(0, 0, "raw_go");

    // WAW on f3, then structural on fsqrt f7
    clr_in(); issue_long(F3);
    cyc(0, 0, "waw_issue");
    clr_in();
    id_valid = 1; id_rd = F3; id_reg_write = 1;
    for (int k = 1; k <= 4; k++) cyc(1, 1, "waw_wait");
    wb_long_valid = 1; wb_long_rd = F3;
    cyc(1, 1, "waw_wb");
    wb_long_valid = 0;
    cyc(0, 1, "waw_go");
    clr_in(); issue_long(F7);
    for (int k = 7; k <= 16; k++) cyc(1, 1, "struct_wait");
    cyc(0, 0, "struct_go");
    clr_in();
    for (int k = 0; k < 7; k++) cyc(0, 1, "div_count");

    // Reset with f7 busy and the divider mid-count
    rst = 1; id_valid = 1; id_rs1 = F7; id_use_rs1 = 1;
    cyc(0, 1, "rst_mid");
    rst = 0;
    cyc(0, 0, "rst_after1");
    cyc(0, 0, "rst_after2");

    // Same-cycle set and clear on f3: set wins
    clr_in(); issue_long(F3); wb_long_valid = 1; wb_long_rd = F3;
    cyc(0, 0, "setclr_issue");
    clr_in();
    id_valid = 1; id_rs2 = F3; id_use_rs2 = 1;
    cyc(1, 1, "setclr_busy");
    wb_long_valid = 1; wb_long_rd = F9;
    cyc(1, 1, "wb_ignored");

    // Flush masks hazards and blocks issue
    clr_in();
    id_valid = 1; id_flush = 1; id_rs1 = F3; id_use_rs1 = 1;
    id_long_op = 1; id_rd = F10; id_reg_write = 1;
    cyc(0, 1, "flush");
    clr_in();
    id_valid = 1; id_rs1 = F10; id_use_rs1 = 1;
    cyc(0, 1, "flush_no_issue");
    clr_in(); wb_long_valid = 1; wb_long_rd = F3;
    cyc(0, 1, "cleanup_wb");
    clr_in();
    id_valid = 1; id_rs1 = F3; id_use_rs1 = 1;
    cyc(0, 1, "raw_cleared");
    clr_in();
    for (int k = 7; k <= 16; k++) cyc(0, 1, "div_drain");
    cyc(0, 0, "div_idle");

    // A long op targeting x0 never marks x0 busy
    issue_long(6'd0);
    cyc(0, 0, "x0_issue");
    clr_in();
    id_valid = 1; id_rs1 = 6'd0; id_use_rs1 = 1; id_rd = 6'd0; id_reg_write = 1;
    cyc(0, 1, "x0_never_busy");

    clr_in();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
